// File: rtl/adc_spi_reader.sv
// SPI read-frame engine answering the scan controller's ADC handshake.
// Runs one CPOL=1, MSB-first frame per start_i and pulses eoc_o with the result.
module adc_spi_reader #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 4,
    parameter int QUIET_CYC  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  cs_no,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  eoc_o
);

    localparam int CNT_W = $clog2(2 * CLK_DIV * FRAME_BITS + QUIET_CYC + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        CSSU,
        SHIFT,
        QUIET,
        DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift_q;

    // NOTE: every output is a flop written here with <=, so no input reaches
    // an output combinationally and all state updates see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the datapath (shift register, result) is reset as well so a
            // frame cut short by reset can never leak partial data.
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            sclk_o  <= 1'b1;
            cs_no   <= 1'b1;
            busy_o  <= 1'b0;
            eoc_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            eoc_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= CSSU;
                        cs_no  <= 1'b0;
                        busy_o <= 1'b1;
                        cnt    <= '0;
                    end
                end

                CSSU: begin
                    if (cnt == HALF_LAST) begin
                        state   <= SHIFT;
                        sclk_o  <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sclk_o) begin
                            // Rising SCLK: the ADC has held this bit for a full low half.
                            sclk_o  <= 1'b1;
                            shift_q <= (shift_q << 1) | FRAME_BITS'(miso_i);
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end else if (bit_cnt == BITS_ALL) begin
                            state <= QUIET;
                            cs_no <= 1'b1;
                        end else begin
                            sclk_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        state  <= DONE;
                        eoc_o  <= 1'b1;
                        data_o <= shift_q[DATA_WIDTH-1:0];
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    sclk_o <= 1'b1;
                    cs_no  <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench: two reader instances (default timing and fastest timing),
// each with a serial ADC model and a cycle-level timeline reference model.
module tb_adc_spi_reader;

    localparam int FB  = 16;
    localparam int DW  = 12;
    localparam int CD0 = 4;
    localparam int QC0 = 4;
    localparam int CD1 = 1;
    localparam int QC1 = 1;
    localparam int L0  = CD0 + 2 * CD0 * FB + QC0;
    localparam int L1  = CD1 + 2 * CD1 * FB + QC1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic miso0  = 1'b0, miso1  = 1'b0;
    logic sclk0, cs0, busy0, eoc0;
    logic sclk1, cs1, busy1, eoc1;
    logic [DW-1:0] data0, data1;
    logic [15:0] word0 = '0, word1 = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int eoc_cnt0 = 0, eoc_cnt1 = 0;
    int rise0 = 0, fall0 = 0, rise1 = 0, fall1 = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    adc_spi_reader dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start0), .miso_i(miso0),
        .sclk_o(sclk0), .cs_no(cs0), .busy_o(busy0), .data_o(data0), .eoc_o(eoc0)
    );

    adc_spi_reader #(.CLK_DIV(CD1), .QUIET_CYC(QC1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1), .miso_i(miso1),
        .sclk_o(sclk1), .cs_no(cs1), .busy_o(busy1), .data_o(data1), .eoc_o(eoc1)
    );

    // Serial ADC: loads its word when selected, presents the next bit on each falling SCLK.
    logic [15:0] adc_sh0, adc_sh1;
    always @(negedge cs0) adc_sh0 = word0;
    always @(negedge sclk0) if (!cs0) begin miso0 = adc_sh0[15]; adc_sh0 = {adc_sh0[14:0], 1'b0}; end
    always @(negedge cs1) adc_sh1 = word1;
    always @(negedge sclk1) if (!cs1) begin miso1 = adc_sh1[15]; adc_sh1 = {adc_sh1[14:0], 1'b0}; end

    always @(posedge sclk0) if (!cs0) rise0++;
    always @(negedge sclk0) if (!cs0) fall0++;
    always @(posedge sclk1) if (!cs1) rise1++;
    always @(negedge sclk1) if (!cs1) fall1++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "k edges since acceptance"; outputs follow from k.
    int            m_act[2];
    int            m_k[2];
    logic [DW-1:0] m_data[2];
    logic [15:0]   m_word[2];

    function automatic int frame_len(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int cdiv(input int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    task automatic model_step(input int i, input logic st, input logic [15:0] w);
        if (m_act[i] != 0) begin
            m_k[i]++;
            if (m_k[i] == frame_len(i)) m_data[i] = m_word[i][DW-1:0];
            if (m_k[i] > frame_len(i)) m_act[i] = 0;
        end else if (st) begin
            m_act[i]  = 1;
            m_k[i]    = 0;
            m_word[i] = w;
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  = 0;
                m_k[i]    = 0;
                m_data[i] = '0;
            end
        end else begin
            model_step(0, start0, word0);
            model_step(1, start1, word1);
        end
    end

    function automatic logic [15:0] expect_out(input int i);
        int   cd        = cdiv(i);
        int   shift_end = cd + 2 * cd * FB;
        int   k         = m_k[i];
        logic csx, sck, bsy, eo;
        if (m_act[i] == 0) begin
            csx = 1'b1; sck = 1'b1; bsy = 1'b0; eo = 1'b0;
        end else begin
            bsy = 1'b1;
            csx = (k < shift_end) ? 1'b0 : 1'b1;
            sck = (k >= cd && k < shift_end) ? (((k - cd) / cd) % 2 == 1) : 1'b1;
            eo  = (k == frame_len(i));
        end
        return {csx, sck, bsy, eo, m_data[i]};
    endfunction

    always @(negedge clk_i) begin
        check("outputs_dut0", {16'h0, cs0, sclk0, busy0, eoc0, data0}, {16'h0, expect_out(0)});
        check("outputs_dut1", {16'h0, cs1, sclk1, busy1, eoc1, data1}, {16'h0, expect_out(1)});
        if (eoc0) eoc_cnt0++;
        if (eoc1) eoc_cnt1++;
    end

    // One frame on instance i; optional extra start pulses at offsets p1/p2 from edge 0.
    task automatic run_frame(input int i, input logic [15:0] w, input int p1, input int p2,
                             output int eoc_at, output int busy_n, output int eoc_n,
                             output logic [DW-1:0] pre_data, output logic [DW-1:0] post_data);
        int            t0;
        logic          b, e, s;
        logic [DW-1:0] d;
        @(negedge clk_i);
        if (i == 0) begin word0 = w; start0 = 1'b1; rise0 = 0; fall0 = 0; end
        else        begin word1 = w; start1 = 1'b1; rise1 = 0; fall1 = 0; end
        @(negedge clk_i);
        if (i == 0) start0 = 1'b0; else start1 = 1'b0;
        t0 = cyc;
        eoc_at = -1; busy_n = 0; eoc_n = 0; pre_data = '0; post_data = '0;
        for (int n = 0; n < 400; n++) begin
            b = (i == 0) ? busy0 : busy1;
            e = (i == 0) ? eoc0  : eoc1;
            d = (i == 0) ? data0 : data1;
            if (b) busy_n++;
            if (e) begin
                eoc_n++;
                if (eoc_at < 0) begin eoc_at = cyc - t0; post_data = d; end
            end else if (eoc_at < 0) begin
                pre_data = d;
            end
            if (eoc_at >= 0 && !b) break;
            @(negedge clk_i);
            s = ((cyc - t0) == p1) || ((cyc - t0) == p2);
            if (i == 0) start0 = s; else start1 = s;
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            eoc_at, busy_n, eoc_n, e0, got, idle_n, t0, len, p1, p2;
        logic [DW-1:0] pre_d, post_d;
        logic [15:0]   w;
        int            vals[3];
        int            et[3];
        logic [DW-1:0] dv[3];
        logic          pb;

        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        check("reset_cs", {31'h0, cs0}, 32'd1);
        check("reset_sclk", {31'h0, sclk0}, 32'd1);
        check("reset_busy", {31'h0, busy0}, 32'd0);
        check("reset_eoc", {31'h0, eoc0}, 32'd0);
        check("reset_data", {20'h0, data0}, 32'h0);

        // Basic frame with default timing.
        run_frame(0, 16'h0ABC, -1, -1, eoc_at, busy_n, eoc_n, pre_d, post_d);
        check("t1_eoc_edge", eoc_at, 32'd136);
        check("t1_data", {20'h0, post_d}, 32'hABC);
        check("t1_busy_cycles", busy_n, 32'd137);
        check("t1_eoc_count", eoc_n, 32'd1);
        check("t1_rise_edges", rise0, 32'd16);
        check("t1_fall_edges", fall0, 32'd16);

        // All ones (leading bits discarded), then all zeros.
        run_frame(0, 16'hFFFF, -1, -1, eoc_at, busy_n, eoc_n, pre_d, post_d);
        check("t2_data_ones", {20'h0, post_d}, 32'hFFF);
        run_frame(0, 16'h0000, -1, -1, eoc_at, busy_n, eoc_n, pre_d, post_d);
        check("t2_hold_before_done", {20'h0, pre_d}, 32'hFFF);
        check("t2_data_zeros", {20'h0, post_d}, 32'h000);

        // Extra start pulses mid-frame are ignored.
        e0 = eoc_cnt0;
        run_frame(0, 16'h0123, 10, 130, eoc_at, busy_n, eoc_n, pre_d, post_d);
        check("t3_eoc_count", eoc_n, 32'd1);
        check("t3_hold_before_done", {20'h0, pre_d}, 32'h000);
        check("t3_data", {20'h0, post_d}, 32'h123);
        repeat (10) @(negedge clk_i);
        check("t3_no_extra_frame", {31'h0, busy0}, 32'd0);
        check("t3_total_eoc", eoc_cnt0 - e0, 32'd1);

        // Start held high: three back-to-back frames.
        vals = '{1, 2, 3};
        got = 0; idle_n = 0; pb = 1'b0;
        @(negedge clk_i);
        word0 = 16'(vals[0]);
        start0 = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (busy0 && !pb && got + 1 < 3) word0 = 16'(vals[got + 1]);
            if (eoc0) begin
                et[got] = cyc; dv[got] = data0; got++;
                if (got == 3) begin start0 = 1'b0; break; end
            end
            if (got >= 1 && !busy0) idle_n++;
            pb = busy0;
            @(negedge clk_i);
        end
        start0 = 1'b0;
        check("t4_frames", got, 32'd3);
        if (got == 3) begin
            check("t4_gap_1_2", et[1] - et[0], 32'd138);
            check("t4_gap_2_3", et[2] - et[1], 32'd138);
            check("t4_data_1", {20'h0, dv[0]}, 32'd1);
            check("t4_data_2", {20'h0, dv[1]}, 32'd2);
            check("t4_data_3", {20'h0, dv[2]}, 32'd3);
            check("t4_idle_cycles", idle_n, 32'd2);
        end

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk_i);
        word0 = 16'h0555;
        start0 = 1'b1;
        @(negedge clk_i);
        start0 = 1'b0;
        t0 = cyc;
        while (cyc - t0 < 60) @(negedge clk_i);
        check("t5_data_before_reset", {20'h0, data0}, 32'd3);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check("t5_cs_async", {31'h0, cs0}, 32'd1);
        check("t5_sclk_async", {31'h0, sclk0}, 32'd1);
        check("t5_data_async", {20'h0, data0}, 32'h0);
        check("t5_busy_async", {31'h0, busy0}, 32'd0);
        e0 = eoc_cnt0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        check("t5_idle_after", {31'h0, busy0}, 32'd0);
        check("t5_no_eoc", eoc_cnt0 - e0, 32'd0);
        run_frame(0, 16'h0F0E, -1, -1, eoc_at, busy_n, eoc_n, pre_d, post_d);
        check("t5_clean_eoc_edge", eoc_at, 32'd136);
        check("t5_clean_data", {20'h0, post_d}, 32'hF0E);

        // Fastest timing instance.
        run_frame(1, 16'h0A5C, -1, -1, eoc_at, busy_n, eoc_n, pre_d, post_d);
        check("t6_eoc_edge", eoc_at, 32'd34);
        check("t6_data", {20'h0, post_d}, 32'hA5C);
        check("t6_busy_cycles", busy_n, 32'd35);
        check("t6_rise_edges", rise1, 32'd16);
        check("t6_fall_edges", fall1, 32'd16);

        // Randomized frames with stray start pulses (including during DONE).
        for (int r = 0; r < 40; r++) begin
            int i;
            i   = int'($urandom_range(0, 1));
            w   = 16'($urandom);
            len = frame_len(i);
            p1  = int'($urandom_range(1, len));
            p2  = ($urandom_range(0, 3) == 0) ? len : -1;
            run_frame(i, w, p1, p2, eoc_at, busy_n, eoc_n, pre_d, post_d);
            check("rand_data", {20'h0, post_d}, {20'h0, w[DW-1:0]});
            check("rand_eoc_edge", eoc_at, len);
            check("rand_eoc_count", eoc_n, 32'd1);
            repeat ($urandom_range(0, 4)) @(negedge clk_i);
        end

        repeat (5) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Responder for the matrix-scan controller's ADC handshake.
- Accepts a start pulse (`start_i`, driven by the controller's `stadc_o`) and runs one SPI read frame from a serial ADC (CPOL=1, MSB first, leading-zero frame).
- Captures the conversion result and returns a one-cycle end-of-conversion pulse (`eoc_o`, feeding the controller's `eoadc_i`).
- Sits between the scan FSM and the ADC pins on the bolometer board.

Parameters:
- FRAME_BITS, 16, SCLK cycles per frame (leading-zero bits plus data bits); must be >= DATA_WIDTH.
- DATA_WIDTH, 12, result width; taken from the last DATA_WIDTH bits of the frame.
- CLK_DIV, 4, clk_i cycles per SCLK half-period; must be >= 1.
- QUIET_CYC, 4, clk_i cycles with cs_no high after the frame, before eoc_o; must be >= 1.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  conversion request; sampled only in IDLE
- miso_i  input  1  ADC serial data
- sclk_o  output  1  SPI clock, idles high
- cs_no  output  1  ADC chip select, active low
- busy_o  output  1  high in every state except IDLE
- data_o  output  DATA_WIDTH  last conversion result; held until the next DONE
- eoc_o  output  1  one-cycle end-of-conversion pulse

Behaviour:
- Reset: one clock, clk_i. rst_ni is asynchronous and active-low. While rst_ni=0 the block forces:
  - state=IDLE
  - sclk_o=1, cs_no=1, busy_o=0, eoc_o=0
  - data_o=0, shift register=0, all counters=0
- All outputs are registered. No combinational path runs from any input to any output.
- States: IDLE, CSSU, SHIFT, QUIET, DONE.
- IDLE:
  - cs_no=1, sclk_o=1.
  - start_i=1 at a clock edge moves to CSSU at that same edge; call this edge 0. cs_no goes low from edge 0.
- CSSU:
  - Lasts CLK_DIV cycles with cs_no=0, sclk_o=1, then moves to SHIFT.
- SHIFT:
  - Lasts 2*CLK_DIV*FRAME_BITS cycles.
  - Each bit is CLK_DIV cycles with sclk_o=0 followed by CLK_DIV cycles with sclk_o=1.
  - miso_i is captured at the clock edge that drives sclk_o from 0 to 1, and shifted into the LSB of a FRAME_BITS shift register, MSB first.
  - Exactly FRAME_BITS falling and FRAME_BITS rising SCLK edges occur per frame.
  - SHIFT ends with sclk_o=1; the next state is QUIET.
- QUIET:
  - Lasts QUIET_CYC cycles with cs_no=1, sclk_o=1, then moves to DONE.
- DONE:
  - Lasts exactly 1 cycle with eoc_o=1.
  - data_o is loaded with shift[DATA_WIDTH-1:0] at the edge entering DONE, so data_o is valid in the same cycle eoc_o is high.
  - The leading FRAME_BITS-DATA_WIDTH bits are discarded without checking.
  - Next state is IDLE.
- Latency: eoc_o is high in the cycle after edge CLK_DIV + 2*CLK_DIV*FRAME_BITS + QUIET_CYC. With defaults that is edge 136, so eoc_o is sampled high at edge 137.
- start_i while busy_o=1 (including during DONE) is ignored and not queued.
- start_i held high continuously gives back-to-back frames, with exactly one IDLE cycle between DONE and the next CSSU.
- rst_ni asserted mid-frame:
  - cs_no and sclk_o go high immediately, without waiting for a clock.
  - The partial frame is dropped and data_o clears to 0.
  - No eoc_o pulse is issued.
  - After rst_ni deasserts, the block stays in IDLE until start_i.
- Counters are sized for 2*CLK_DIV*FRAME_BITS and must not wrap within a frame. The bit counter stops at FRAME_BITS.

Test Plan:
- Defaults, ADC model returns 16'h0ABC (4 zeros + 12'hABC):
  - data_o=12'hABC, eoc_o high for exactly 1 cycle, sampled high at edge 137.
  - 16 rising sclk_o edges inside the cs_no-low window.
  - busy_o high from edge 0 through DONE.
- Model returns 16'hFFFF: data_o=12'hFFF, leading bits discarded. Next frame with 16'h0000 gives data_o=12'h000; data_o holds 12'hFFF until that DONE.
- Second start_i pulses at cycles 10 and 130 of an active frame: no extra frame, exactly one eoc_o pulse. data_o changes only at that pulse.
- start_i held high for 3 frames (values 1, 2, 3): three eoc_o pulses 138 cycles apart, data_o = 1, 2, 3 in turn, one IDLE cycle between frames.
- rst_ni pulsed low at cycle 60 (mid-SHIFT), asynchronous to clk_i: cs_no=1, sclk_o=1, data_o=0 immediately and no eoc_o. A subsequent start_i produces a clean full frame.
- CLK_DIV=1, QUIET_CYC=1:
  - sclk_o toggles every clk_i cycle, with 16 rising edges.
  - eoc_o is sampled high at edge 35.
  - Correct data is captured.
